// File: rtl/mc_controller.sv
`timescale 1ns/1ps
// Multi-cycle control unit: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB
// (plus MDWAIT for mult/div) and is the sole source of datapath write enables.
module mc_controller #(
    parameter int ALU_CTRL_W  = 5,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    output logic                  pcWr,
    output logic                  irWr,
    output logic [1:0]            pcSrc,
    output logic [ALU_CTRL_W-1:0] aluCtrl,
    output logic                  grfWr,
    output logic [1:0]            grfDst,
    output logic [1:0]            grfSrc,
    output logic                  hiLoSel,
    output logic                  dmWr,
    output logic                  mdStart,
    output logic [1:0]            mdOp,
    output logic                  mdBusy,
    output logic                  illegal,
    output logic [2:0]            dbg_state
);

    // dbg_state encoding: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 MDWAIT=5
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic is_r, is_addu, is_subu, is_jr, is_mfhi, is_mflo;
    logic is_mult, is_multu, is_div, is_divu, is_md;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, legal;
    logic [CNT_W-1:0] md_load;
    logic [1:0]       md_op;

    always_comb begin
        is_r     = (op == 6'h00);
        is_addu  = is_r && (funct == 6'h21);
        is_subu  = is_r && (funct == 6'h23);
        is_jr    = is_r && (funct == 6'h08);
        is_mfhi  = is_r && (funct == 6'h10);
        is_mflo  = is_r && (funct == 6'h12);
        is_mult  = is_r && (funct == 6'h18);
        is_multu = is_r && (funct == 6'h19);
        is_div   = is_r && (funct == 6'h1A);
        is_divu  = is_r && (funct == 6'h1B);
        is_ori   = (op == 6'h0D);
        is_lui   = (op == 6'h0F);
        is_lw    = (op == 6'h23);
        is_sw    = (op == 6'h2B);
        is_beq   = (op == 6'h04);
        is_jal   = (op == 6'h03);
        is_md    = is_mult | is_multu | is_div | is_divu;
        legal    = is_addu | is_subu | is_jr | is_mfhi | is_mflo | is_md |
                   is_ori | is_lui | is_lw | is_sw | is_beq | is_jal;
        md_op    = {is_div | is_divu, is_multu | is_divu};
        md_load  = (is_div | is_divu) ? DIV_LOAD : MULT_LOAD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: state <= (is_jal || is_jr || !legal) ? S_FETCH : S_EXEC;
                S_EXEC: begin
                    if (is_md) begin
                        cnt   <= md_load;
                        state <= (md_load != '0) ? S_MDWAIT : S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state <= S_MEM;
                    end else if (is_beq) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM:    state <= is_lw ? S_WB : S_FETCH;
                S_WB:     state <= S_FETCH;
                S_MDWAIT: begin
                    // Leave on the cycle the counter steps from 1 to 0.
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) state <= S_FETCH;
                end
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded combinationally and forced idle while reset is held.
    always_comb begin
        pcWr    = 1'b0;
        irWr    = 1'b0;
        pcSrc   = 2'd0;
        aluCtrl = '0;
        grfWr   = 1'b0;
        grfDst  = 2'd0;
        grfSrc  = 2'd0;
        hiLoSel = 1'b0;
        dmWr    = 1'b0;
        mdStart = 1'b0;
        mdOp    = 2'd0;
        mdBusy  = 1'b0;
        illegal = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    irWr = 1'b1;
                    pcWr = 1'b1;
                end
                S_DECODE: begin
                    if (is_jal) begin
                        pcWr   = 1'b1;
                        pcSrc  = 2'd2;
                        grfWr  = 1'b1;
                        grfDst = 2'd2;
                        grfSrc = 2'd2;
                    end else if (is_jr) begin
                        pcWr  = 1'b1;
                        pcSrc = 2'd3;
                    end else if (!legal) begin
                        illegal = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_addu)        aluCtrl = ALU_CTRL_W'(1);
                    if (is_subu)        aluCtrl = ALU_CTRL_W'(2);
                    if (is_ori)         aluCtrl = ALU_CTRL_W'(6);
                    if (is_lui)         aluCtrl = ALU_CTRL_W'(7);
                    if (is_lw || is_sw) aluCtrl = ALU_CTRL_W'(8);
                    if (is_beq) begin
                        aluCtrl = ALU_CTRL_W'(2);
                        pcWr    = zero;
                        pcSrc   = zero ? 2'd1 : 2'd0;
                    end
                    if (is_md) begin
                        mdStart = 1'b1;
                        mdOp    = md_op;
                        mdBusy  = (md_load != '0);
                    end
                end
                S_MEM: dmWr = is_sw;
                S_WB: begin
                    grfWr = 1'b1;
                    if (is_ori || is_lui || is_lw) grfDst = 2'd1;
                    if (is_lw) grfSrc = 2'd1;
                    if (is_mfhi || is_mflo) grfSrc = 2'd3;
                    hiLoSel = is_mfhi;
                end
                S_MDWAIT: mdBusy = (cnt != '0);
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mc_controller.sv
`timescale 1ns/1ps
// Bench for mc_controller: instance a uses default latencies, instance b uses DIV_CYCLES=1.
module tb_mc_controller;

    typedef struct packed {
        logic       pcWr;
        logic       irWr;
        logic [1:0] pcSrc;
        logic [4:0] alu;
        logic       grfWr;
        logic [1:0] grfDst;
        logic [1:0] grfSrc;
        logic       hiLo;
        logic       dmWr;
        logic       mdStart;
        logic [1:0] mdOp;
        logic       mdBusy;
        logic       illegal;
        logic [2:0] st;
    } ctl_t;

    localparam int CW = $bits(ctl_t);
    localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
                           ST_MEM = 3'd3, ST_WB = 3'd4, ST_MDWAIT = 3'd5;
    localparam int A_MULT = 5, A_DIV = 10, B_MULT = 5, B_DIV = 1;

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_MFHI, K_MFLO, K_MULT, K_MULTU, K_DIV, K_DIVU,
                      K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_ILL} kind_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic [5:0] op_a = '0, funct_a = '0, op_b = '0, funct_b = '0;
    logic       zero_a = 1'b0, zero_b = 1'b0;

    logic       pc_wr_a, ir_wr_a, grf_wr_a, hi_lo_a, dm_wr_a, md_start_a, md_busy_a, illegal_a;
    logic [1:0] pc_src_a, grf_dst_a, grf_src_a, md_op_a;
    logic [4:0] alu_a;
    logic [2:0] st_a;
    logic       pc_wr_b, ir_wr_b, grf_wr_b, hi_lo_b, dm_wr_b, md_start_b, md_busy_b, illegal_b;
    logic [1:0] pc_src_b, grf_dst_b, grf_src_b, md_op_b;
    logic [4:0] alu_b;
    logic [2:0] st_b;

    mc_controller u_a (
        .clk(clk), .reset(rst_a), .op(op_a), .funct(funct_a), .zero(zero_a),
        .pcWr(pc_wr_a), .irWr(ir_wr_a), .pcSrc(pc_src_a), .aluCtrl(alu_a),
        .grfWr(grf_wr_a), .grfDst(grf_dst_a), .grfSrc(grf_src_a), .hiLoSel(hi_lo_a),
        .dmWr(dm_wr_a), .mdStart(md_start_a), .mdOp(md_op_a), .mdBusy(md_busy_a),
        .illegal(illegal_a), .dbg_state(st_a)
    );

    mc_controller #(.MULT_CYCLES(B_MULT), .DIV_CYCLES(B_DIV)) u_b (
        .clk(clk), .reset(rst_b), .op(op_b), .funct(funct_b), .zero(zero_b),
        .pcWr(pc_wr_b), .irWr(ir_wr_b), .pcSrc(pc_src_b), .aluCtrl(alu_b),
        .grfWr(grf_wr_b), .grfDst(grf_dst_b), .grfSrc(grf_src_b), .hiLoSel(hi_lo_b),
        .dmWr(dm_wr_b), .mdStart(md_start_b), .mdOp(md_op_b), .mdBusy(md_busy_b),
        .illegal(illegal_b), .dbg_state(st_b)
    );

    logic [CW-1:0] got_a, got_b;
    assign got_a = {pc_wr_a, ir_wr_a, pc_src_a, alu_a, grf_wr_a, grf_dst_a, grf_src_a, hi_lo_a,
                    dm_wr_a, md_start_a, md_op_a, md_busy_a, illegal_a, st_a};
    assign got_b = {pc_wr_b, ir_wr_b, pc_src_b, alu_b, grf_wr_b, grf_dst_b, grf_src_b, hi_lo_b,
                    dm_wr_b, md_start_b, md_op_b, md_busy_b, illegal_b, st_b};

    // scoreboard
    logic [CW-1:0] exp_a[$];
    logic [CW-1:0] exp_b[$];
    ctl_t          plan_q[$];
    int            checks = 0;
    int            fails = 0;

    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: begin
                case (f)
                    6'h21: return K_ADDU;
                    6'h23: return K_SUBU;
                    6'h08: return K_JR;
                    6'h10: return K_MFHI;
                    6'h12: return K_MFLO;
                    6'h18: return K_MULT;
                    6'h19: return K_MULTU;
                    6'h1A: return K_DIV;
                    6'h1B: return K_DIVU;
                    default: return K_ILL;
                endcase
            end
            6'h0D: return K_ORI;
            6'h0F: return K_LUI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    // Reference model: the per-cycle control vectors one instruction should produce.
    task automatic plan_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input int mult_c, input int div_c);
        kind_t k;
        ctl_t  c;
        int    lat;
        k = classify(o, f);
        c = '0; c.st = ST_FETCH; c.pcWr = 1'b1; c.irWr = 1'b1;
        plan_q.push_back(c);
        c = '0; c.st = ST_DECODE;
        if (k == K_JAL) begin
            c.pcWr = 1'b1; c.pcSrc = 2'd2; c.grfWr = 1'b1; c.grfDst = 2'd2; c.grfSrc = 2'd2;
        end else if (k == K_JR) begin
            c.pcWr = 1'b1; c.pcSrc = 2'd3;
        end else if (k == K_ILL) begin
            c.illegal = 1'b1;
        end
        plan_q.push_back(c);
        if (k == K_JAL || k == K_JR || k == K_ILL) return;
        c = '0; c.st = ST_EXEC;
        lat = 0;
        case (k)
            K_ADDU: c.alu = 5'd1;
            K_SUBU: c.alu = 5'd2;
            K_ORI:  c.alu = 5'd6;
            K_LUI:  c.alu = 5'd7;
            K_LW, K_SW: c.alu = 5'd8;
            K_BEQ: begin
                c.alu = 5'd2; c.pcWr = z; c.pcSrc = z ? 2'd1 : 2'd0;
            end
            K_MULT, K_MULTU, K_DIV, K_DIVU: begin
                lat = (k == K_MULT || k == K_MULTU) ? mult_c : div_c;
                c.mdStart = 1'b1;
                c.mdOp = (k == K_MULT) ? 2'd0 : (k == K_MULTU) ? 2'd1 : (k == K_DIV) ? 2'd2 : 2'd3;
                c.mdBusy = (lat > 1);
            end
            default: ;
        endcase
        plan_q.push_back(c);
        if (lat > 0) begin
            for (int i = 1; i < lat; i++) begin
                c = '0; c.st = ST_MDWAIT; c.mdBusy = 1'b1;
                plan_q.push_back(c);
            end
            return;
        end
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            c = '0; c.st = ST_MEM; c.dmWr = (k == K_SW);
            plan_q.push_back(c);
            if (k == K_SW) return;
        end
        c = '0; c.st = ST_WB; c.grfWr = 1'b1;
        case (k)
            K_ORI, K_LUI: c.grfDst = 2'd1;
            K_LW: begin c.grfDst = 2'd1; c.grfSrc = 2'd1; end
            K_MFHI: begin c.grfSrc = 2'd3; c.hiLo = 1'b1; end
            K_MFLO: c.grfSrc = 2'd3;
            default: ;
        endcase
        plan_q.push_back(c);
    endtask

    // driver tasks: always entered and left 1ns after a rising edge
    task automatic run_instr(input bit which, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int cut);
        int n;
        plan_q.delete();
        plan_instr(o, f, z, which ? B_MULT : A_MULT, which ? B_DIV : A_DIV);
        n = (cut > 0 && cut < plan_q.size()) ? cut : plan_q.size();
        if (which) begin op_b = o; funct_b = f; zero_b = z; end
        else       begin op_a = o; funct_a = f; zero_a = z; end
        for (int i = 0; i < n; i++) begin
            if (which) exp_b.push_back(plan_q[i]);
            else       exp_a.push_back(plan_q[i]);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input bit which, input int n);
        if (which) rst_b = 1'b0; else rst_a = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (which) exp_b.push_back('0); else exp_a.push_back('0);
            @(posedge clk);
            #1;
        end
        if (which) rst_b = 1'b1; else rst_a = 1'b1;
    endtask

    task automatic rand_instr(output logic [5:0] o, output logic [5:0] f);
        int k;
        k = $urandom_range(0, 15);
        o = 6'h00;
        f = 6'($urandom_range(0, 63));
        case (k)
            0: o = 6'h0D;  1: o = 6'h0F;  2: o = 6'h23;  3: o = 6'h2B;
            4: o = 6'h04;  5: o = 6'h03;
            6: f = 6'h21;  7: f = 6'h23;  8: f = 6'h08;  9: f = 6'h10;
            10: f = 6'h12; 11: f = 6'h18; 12: f = 6'h19; 13: f = 6'h1A;
            14: f = 6'h1B;
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    o = 6'($urandom_range(0, 63));
                    if (classify(o, f) != K_ILL) o = 6'h3F;
                end else if (classify(o, f) != K_ILL) begin
                    f = 6'h3F;
                end
            end
        endcase
    endtask

    task automatic check(input string nm, input logic [CW-1:0] e, input logic [CW-1:0] g);
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s t=%0t state got=%0d exp=%0d ctl got=%h exp=%h",
                     nm, $time, g[2:0], e[2:0], g, e);
        end
    endtask

    // monitor
    initial begin
        logic [CW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                check("ctl_a", e, got_a);
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                check("ctl_b", e, got_b);
            end
        end
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1);
    end

    initial begin
        logic [5:0] o, f;
        @(posedge clk);
        #1;
        // directed sequence on instance a
        hold_reset(1'b0, 3);
        run_instr(1'b0, 6'h0D, 6'h00, 1'b0, 0);
        run_instr(1'b0, 6'h23, 6'h00, 1'b0, 0);
        run_instr(1'b0, 6'h2B, 6'h00, 1'b0, 0);
        run_instr(1'b0, 6'h04, 6'h00, 1'b1, 0);
        run_instr(1'b0, 6'h04, 6'h00, 1'b0, 0);
        run_instr(1'b0, 6'h00, 6'h18, 1'b0, 0);
        run_instr(1'b0, 6'h03, 6'h00, 1'b0, 0);
        run_instr(1'b0, 6'h00, 6'h08, 1'b0, 0);
        run_instr(1'b0, 6'h3F, 6'h00, 1'b0, 0);
        run_instr(1'b0, 6'h00, 6'h10, 1'b0, 0);
        run_instr(1'b0, 6'h00, 6'h12, 1'b0, 0);
        // div cut after the MDWAIT cycle holding 7; reset lands while the counter holds 6
        run_instr(1'b0, 6'h00, 6'h1A, 1'b0, 6);
        hold_reset(1'b0, 2);
        run_instr(1'b0, 6'h00, 6'h21, 1'b0, 0);
        for (int i = 0; i < 150; i++) begin
            rand_instr(o, f);
            run_instr(1'b0, o, f, 1'($urandom_range(0, 1)), 0);
        end
        rst_a = 1'b0;
        // instance b: single-cycle divide never enters MDWAIT
        hold_reset(1'b1, 2);
        run_instr(1'b1, 6'h00, 6'h1A, 1'b0, 0);
        run_instr(1'b1, 6'h00, 6'h1B, 1'b0, 0);
        run_instr(1'b1, 6'h00, 6'h18, 1'b0, 0);
        for (int i = 0; i < 40; i++) begin
            rand_instr(o, f);
            run_instr(1'b1, o, f, 1'($urandom_range(0, 1)), 0);
        end
        @(negedge clk);
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            fails++;
            $display("FAIL drain left_a=%0d left_b=%0d exp=0", exp_a.size(), exp_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
